// File: rtl/med_seq.sv
// Window sequencer for the serial median sort core. It buffers one window of pixels,
// bursts it into the core, runs the compare/drop schedule and strobes out the median.
module med_seq #(
   parameter int NBITS   = 8,
   parameter int NPIXELS = 9
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [NBITS-1:0] pix_i,
   input  logic             pix_valid_i,
   output logic             pix_ready_o,
   output logic [NBITS-1:0] sc_di_o,
   output logic             sc_dsi_o,
   output logic             sc_byp_o,
   input  logic [NBITS-1:0] sc_do_i,
   output logic [NBITS-1:0] med_o,
   output logic             med_valid_o
);

   localparam int P  = (NPIXELS - 1) / 2;
   localparam int CW = $clog2(NPIXELS + 1);
   localparam int IW = $clog2(NPIXELS);
   localparam int PW = $clog2(P + 1);

   localparam logic [CW-1:0] FULL   = CW'(NPIXELS);
   localparam logic [CW-1:0] FULLM1 = CW'(NPIXELS - 1);
   localparam logic [IW-1:0] LASTK  = IW'(NPIXELS - 1);
   localparam logic [IW-1:0] LASTC  = IW'(NPIXELS - 2);
   localparam logic [PW-1:0] LASTP  = PW'(P);

   typedef enum logic [2:0] {IDLE, BURST, COMP, DROP, OUT} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [IW-1:0]    k, k_nxt;
   logic [PW-1:0]    pass, pass_nxt;
   logic             cnt_clr;
   logic             accept;
   logic [NBITS-1:0] pbuf [NPIXELS];

   assign pix_ready_o = (cnt < FULL) && (state != BURST);
   assign accept      = pix_valid_i && pix_ready_o;

   // Buffer holds data only; cnt alone decides validity, so no reset needed.
   always_ff @(posedge CLK) begin
      if (accept) pbuf[cnt[IW-1:0]] <= pix_i;
   end

   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      pass_nxt  = pass;
      cnt_clr   = 1'b0;
      sc_dsi_o  = 1'b0;
      sc_byp_o  = 1'b0;
      sc_di_o   = '0;
      case (state)
         IDLE: begin
            // Look ahead at the completing beat so BURST starts the cycle after it.
            if (cnt == FULL || (accept && cnt == FULLM1)) begin
               state_nxt = BURST;
               k_nxt     = '0;
            end
         end
         BURST: begin
            sc_dsi_o = 1'b1;
            sc_byp_o = 1'b1;
            sc_di_o  = pbuf[k];
            if (k == LASTK) begin
               k_nxt     = '0;
               pass_nxt  = '0;
               cnt_clr   = 1'b1;
               state_nxt = COMP;
            end else begin
               k_nxt = k + 1'b1;
            end
         end
         COMP: begin
            if (k == LASTC) begin
               k_nxt     = '0;
               state_nxt = (pass == LASTP) ? OUT : DROP;
            end else begin
               k_nxt = k + 1'b1;
            end
         end
         DROP: begin
            // Shift the current max off the top; the injected zero never wins later.
            sc_dsi_o  = 1'b1;
            sc_byp_o  = 1'b1;
            pass_nxt  = pass + 1'b1;
            state_nxt = COMP;
         end
         OUT: begin
            k_nxt     = '0;
            state_nxt = (cnt == FULL) ? BURST : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state       <= IDLE;
         k           <= '0;
         pass        <= '0;
         cnt         <= '0;
         med_o       <= '0;
         med_valid_o <= 1'b0;
      end else begin
         state       <= state_nxt;
         k           <= k_nxt;
         pass        <= pass_nxt;
         med_valid_o <= (state == OUT);
         if (state == OUT) med_o <= sc_do_i;
         if (cnt_clr)     cnt <= '0;
         else if (accept) cnt <= cnt + 1'b1;
      end
   end

endmodule
